// File: rtl/commit_arbiter.sv
// commit_arbiter: merges five buffered execute results and a paired mul/div result onto two commit lanes
module commit_arbiter #(
   parameter int BUS_W       = 160,
   parameter int FIFO_DEPTH  = 2,
   parameter int MD_MAX_WAIT = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_flush,
   input  logic             i_alu1_valid,
   output logic             o_alu1_ready,
   input  logic [BUS_W-1:0] i_alu1_bus,
   input  logic             i_bru_valid,
   output logic             o_bru_ready,
   input  logic [BUS_W-1:0] i_bru_bus,
   input  logic             i_alu2_valid,
   output logic             o_alu2_ready,
   input  logic [BUS_W-1:0] i_alu2_bus,
   input  logic             i_agu_valid,
   output logic             o_agu_ready,
   input  logic [BUS_W-1:0] i_agu_bus,
   input  logic             i_spu_valid,
   output logic             o_spu_ready,
   input  logic [BUS_W-1:0] i_spu_bus,
   input  logic             i_md_valid,
   output logic             o_md_ready,
   input  logic [BUS_W-1:0] i_md_bus1,
   input  logic [BUS_W-1:0] i_md_bus2,
   input  logic             i_commit_allowin,
   output logic             o_commit_valid1,
   output logic [BUS_W-1:0] o_commit_bus1,
   output logic             o_commit_valid2,
   output logic [BUS_W-1:0] o_commit_bus2
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [3:0] MAXW = 4'(MD_MAX_WAIT);

   logic [4:0]       w_valid, w_ready, w_push, w_pop, w_ne;
   logic [BUS_W-1:0] w_bus [5];
   logic [BUS_W-1:0] w_head [5];
   logic [2:0]       w_ne2;
   logic [1:0]       w_g2, w_c1, w_c2;
   logic             w_g1, w_all_empty, w_hold, w_md_grant, w_go, w_have1, w_have2;
   logic             r_rr1;
   logic [1:0]       r_rr2;
   logic [3:0]       r_md_wait;

   // source index order: 0 alu1, 1 bru (lane 1); 2 alu2, 3 agu, 4 spu (lane 2)
   assign w_valid = {i_spu_valid, i_agu_valid, i_alu2_valid, i_bru_valid, i_alu1_valid};
   assign w_bus[0] = i_alu1_bus;
   assign w_bus[1] = i_bru_bus;
   assign w_bus[2] = i_alu2_bus;
   assign w_bus[3] = i_agu_bus;
   assign w_bus[4] = i_spu_bus;
   assign {o_spu_ready, o_agu_ready, o_alu2_ready, o_bru_ready, o_alu1_ready} = w_ready;

   generate
      for (genvar g = 0; g < 5; g++) begin : g_fifo
         logic [BUS_W-1:0] r_mem [FIFO_DEPTH];
         logic [PW-1:0]    r_rp, r_wp;
         logic [CW-1:0]    r_cnt;
         assign w_ready[g] = r_cnt < CW'(FIFO_DEPTH);
         assign w_ne[g]    = r_cnt != '0;
         assign w_push[g]  = w_valid[g] & w_ready[g] & ~i_flush;
         assign w_head[g]  = r_mem[r_rp];
         // payload storage; occupancy alone decides which entries are live
         always_ff @(posedge i_clk)
            if (w_push[g]) r_mem[r_wp] <= w_bus[g];
         // read/write pointers and occupancy, emptied by reset or flush
         always_ff @(posedge i_clk or negedge i_reset_n)
            if (!i_reset_n) begin
               r_rp  <= '0;
               r_wp  <= '0;
               r_cnt <= '0;
            end else if (i_flush) begin
               r_rp  <= '0;
               r_wp  <= '0;
               r_cnt <= '0;
            end else begin
               if (w_push[g]) r_wp <= r_wp + 1'b1;
               if (w_pop[g]) r_rp <= r_rp + 1'b1;
               r_cnt <= r_cnt + CW'(w_push[g]) - CW'(w_pop[g]);
            end
      end
   endgenerate

   // mul/div wins when the buffers are drained or it has starved; otherwise each lane round-robins its sources
   always_comb begin
      w_all_empty = ~|w_ne;
      w_hold      = i_md_valid && (r_md_wait == MAXW);
      w_md_grant  = i_reset_n && i_md_valid && i_commit_allowin && !i_flush && (w_all_empty || w_hold);
      w_have1     = |w_ne[1:0];
      w_g1        = r_rr1 ? w_ne[1] : ~w_ne[0];
      w_ne2       = w_ne[4:2];
      w_have2     = |w_ne2;
      w_c1        = (r_rr2 == 2'd2) ? 2'd0 : r_rr2 + 2'd1;
      w_c2        = (r_rr2 == 2'd0) ? 2'd2 : r_rr2 - 2'd1;
      w_g2        = w_ne2[r_rr2] ? r_rr2 : w_ne2[w_c1] ? w_c1 : w_c2;
      w_go        = !w_md_grant && !w_hold && i_commit_allowin && !i_flush;
      w_pop       = {3'(w_go && w_have2) << w_g2, 2'(w_go && w_have1) << w_g1};
      o_md_ready      = w_md_grant;
      o_commit_valid1 = w_md_grant || (w_have1 && !w_hold);
      o_commit_valid2 = w_md_grant || (w_have2 && !w_hold);
      o_commit_bus1   = w_md_grant ? i_md_bus1 : o_commit_valid1 ? w_head[3'(w_g1)] : '0;
      o_commit_bus2   = w_md_grant ? i_md_bus2 : o_commit_valid2 ? w_head[3'd2 + 3'(w_g2)] : '0;
   end

   // round-robin pointers move one past each lane winner; starvation counter saturates while mul/div waits
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         r_rr1     <= 1'b0;
         r_rr2     <= 2'd0;
         r_md_wait <= 4'd0;
      end else if (i_flush) begin
         r_rr1     <= 1'b0;
         r_rr2     <= 2'd0;
         r_md_wait <= 4'd0;
      end else begin
         if (w_go && w_have1) r_rr1 <= ~w_g1;
         if (w_go && w_have2) r_rr2 <= (w_g2 == 2'd2) ? 2'd0 : w_g2 + 2'd1;
         r_md_wait <= (!i_md_valid || w_md_grant) ? 4'd0 : (r_md_wait < MAXW) ? r_md_wait + 4'd1 : r_md_wait;
      end
endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_commit_arbiter;
   localparam int W   = 32;
   localparam int DEP = 2;
   localparam int MW  = 8;
   localparam logic [W-1:0] MD1 = 32'hD1D1_0001;
   localparam logic [W-1:0] MD2 = 32'hD2D2_0002;

   logic clk = 0, rst_n = 0, flush = 0, allowin = 0, md_valid = 0;
   logic [4:0]   v = '0;
   logic [4:0]   rdy;
   logic         md_ready, cv1, cv2;
   logic [W-1:0] cb1, cb2;
   logic [W-1:0] sbus [5];
   int           seq [5];
   logic [W-1:0] q [5][$];
   int           rr1 = 0, rr2 = 0, mdw = 0;
   int           n_vec = 0, n_err = 0;
   int           n;

   always #5 clk = ~clk;

   always_comb for (int s = 0; s < 5; s++) sbus[s] = {8'(s + 1), 24'(seq[s])};

   commit_arbiter #(.BUS_W(W), .FIFO_DEPTH(DEP), .MD_MAX_WAIT(MW)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
      .i_alu1_valid(v[0]), .o_alu1_ready(rdy[0]), .i_alu1_bus(sbus[0]),
      .i_bru_valid(v[1]), .o_bru_ready(rdy[1]), .i_bru_bus(sbus[1]),
      .i_alu2_valid(v[2]), .o_alu2_ready(rdy[2]), .i_alu2_bus(sbus[2]),
      .i_agu_valid(v[3]), .o_agu_ready(rdy[3]), .i_agu_bus(sbus[3]),
      .i_spu_valid(v[4]), .o_spu_ready(rdy[4]), .i_spu_bus(sbus[4]),
      .i_md_valid(md_valid), .o_md_ready(md_ready), .i_md_bus1(MD1), .i_md_bus2(MD2),
      .i_commit_allowin(allowin),
      .o_commit_valid1(cv1), .o_commit_bus1(cb1),
      .o_commit_valid2(cv2), .o_commit_bus2(cb2)
   );

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // one clock: compare DUT against the model at the falling edge, then advance the model at the rising edge
   task automatic cycle();
      bit all_e, hold, grant, ev1, ev2;
      int c1, c2, s;
      bit [4:0] pu;
      logic [W-1:0] eb1, eb2;
      @(negedge clk);
      if (!rst_n) begin
         for (int k = 0; k < 5; k++) q[k].delete();
         rr1 = 0; rr2 = 0; mdw = 0;
      end
      all_e = 1;
      for (int k = 0; k < 5; k++) if (q[k].size() != 0) all_e = 0;
      hold  = md_valid && mdw == MW;
      grant = rst_n && md_valid && allowin && !flush && (all_e || mdw == MW);
      c1 = -1;
      for (int k = 0; k < 2; k++) begin s = (rr1 + k) % 2; if (c1 < 0 && q[s].size() > 0) c1 = s; end
      c2 = -1;
      for (int k = 0; k < 3; k++) begin s = 2 + (rr2 + k) % 3; if (c2 < 0 && q[s].size() > 0) c2 = s; end
      ev1 = grant || (c1 >= 0 && !hold);
      ev2 = grant || (c2 >= 0 && !hold);
      eb1 = grant ? MD1 : ev1 ? q[c1][0] : '0;
      eb2 = grant ? MD2 : ev2 ? q[c2][0] : '0;
      for (int k = 0; k < 5; k++) chk($sformatf("ready%0d", k), W'(rdy[k]), W'(q[k].size() < DEP));
      chk("md_ready", W'(md_ready), W'(grant));
      chk("valid1", W'(cv1), W'(ev1));
      chk("bus1", cb1, eb1);
      chk("valid2", W'(cv2), W'(ev2));
      chk("bus2", cb2, eb2);
      for (int k = 0; k < 5; k++) pu[k] = rst_n && !flush && v[k] && q[k].size() < DEP;
      @(posedge clk);
      if (rst_n) begin
         if (flush) begin
            for (int k = 0; k < 5; k++) q[k].delete();
            rr1 = 0; rr2 = 0; mdw = 0;
         end else begin
            if (!grant && !hold && allowin) begin
               if (c1 >= 0) begin void'(q[c1].pop_front()); rr1 = (c1 + 1) % 2; end
               if (c2 >= 0) begin void'(q[c2].pop_front()); rr2 = (c2 - 1) % 3; end
            end
            for (int k = 0; k < 5; k++) if (pu[k]) q[k].push_back(sbus[k]);
            mdw = (!md_valid || grant) ? 0 : (mdw < MW ? mdw + 1 : mdw);
         end
      end
      #1;
      for (int k = 0; k < 5; k++) if (pu[k]) seq[k]++;
   endtask

   initial begin
      for (int k = 0; k < 5; k++) seq[k] = 0;
      // reset state
      #1;
      chk("rst_valid1", W'(cv1), '0);
      chk("rst_ready", W'(rdy), W'(5'h1f));
      cycle(); cycle();
      rst_n = 1;
      // lane 1 alternation between alu1 and bru
      v = 5'b00011; allowin = 1;
      cycle();
      chk("alt_first", cb1, 32'h0100_0000);
      cycle();
      chk("alt_second", cb1, 32'h0200_0000);
      cycle();
      chk("alt_third", cb1, 32'h0100_0001);
      repeat (5) cycle();
      v = '0;
      repeat (6) cycle();
      // backpressure on alu2 with commit stalled
      v = 5'b00100; allowin = 0;
      cycle(); cycle();
      chk("alu2_full_ready", W'(rdy[2]), '0);
      chk("alu2_stall_bus", cb2, 32'h0300_0000);
      cycle();
      chk("alu2_stable_bus", cb2, 32'h0300_0000);
      chk("alu2_third_refused", W'(seq[2]), 32'd2);
      allowin = 1; v = '0;
      repeat (4) cycle();
      // mul/div with all buffers empty
      md_valid = 1;
      #1;
      chk("md_empty_ready", W'(md_ready), 32'd1);
      chk("md_empty_bus1", cb1, MD1);
      chk("md_empty_bus2", cb2, MD2);
      cycle();
      md_valid = 0;
      cycle();
      // mul/div starvation while agu streams
      v = 5'b01000;
      cycle();
      md_valid = 1;
      #1;
      n = 1;
      while (!md_ready && n < 20) begin cycle(); n++; end
      chk("md_starve_cycles", W'(n), 32'd9);
      chk("md_starve_bus2", cb2, MD2);
      cycle();
      md_valid = 0; v = '0;
      repeat (4) cycle();
      // flush drops buffered and same-cycle pushes
      allowin = 0; v = 5'b11001;
      cycle();
      flush = 1; v = 5'b11111;
      cycle();
      flush = 0; v = '0;
      chk("flush_valid1", W'(cv1), '0);
      chk("flush_valid2", W'(cv2), '0);
      chk("flush_ready", W'(rdy), W'(5'h1f));
      allowin = 1;
      repeat (3) cycle();
      // reset mid-stream
      v = 5'b00001;
      repeat (3) cycle();
      #2 rst_n = 0;
      #1;
      chk("midrst_valid1", W'(cv1), '0);
      chk("midrst_bus1", cb1, '0);
      chk("midrst_ready", W'(rdy), W'(5'h1f));
      cycle();
      rst_n = 1;
      cycle();
      chk("post_rst_valid1", W'(cv1), 32'd1);
      chk("post_rst_src", W'(cb1[31:24]), 32'd1);
      v = '0;
      repeat (3) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/commit_arbiter.md
COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 SHALL have parameter BUS_W, default 160, width of one execute-to-commit bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, entries per lane-source FIFO (power of two, >=2).
REQ-003 SHALL have parameter MD_MAX_WAIT, default 8, mul/div starvation limit in cycles (1..15).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous pipeline flush.
REQ-007 alu1_valid/alu1_ready/alu1_bus  in/out/in  1/1/BUS_W  lane-1 source 0.
REQ-008 bru_valid/bru_ready/bru_bus  in/out/in  1/1/BUS_W  lane-1 source 1.
REQ-009 alu2_valid/alu2_ready/alu2_bus  in/out/in  1/1/BUS_W  lane-2 source 0.
REQ-010 agu_valid/agu_ready/agu_bus  in/out/in  1/1/BUS_W  lane-2 source 1.
REQ-011 spu_valid/spu_ready/spu_bus  in/out/in  1/1/BUS_W  lane-2 source 2.
REQ-012 md_valid/md_ready  in/out  1/1  mul/div paired result handshake.
REQ-013 md_bus1/md_bus2  in  BUS_W each  mul/div results for lane 1/lane 2.
REQ-014 commit_allowin  in  1  commit stage accepts both lanes this cycle.
REQ-015 commit_valid1/commit_bus1  out  1/BUS_W  lane-1 result to commit.
REQ-016 commit_valid2/commit_bus2  out  1/BUS_W  lane-2 result to commit.

Function
REQ-017 Each of the five lane sources SHALL own a FIFO of FIFO_DEPTH entries; push on src_valid && src_ready.
REQ-018 src_ready SHALL be 1 iff that FIFO count < FIFO_DEPTH, from registered count only (no same-cycle pop bypass).
REQ-019 Pushed data SHALL be visible on commit outputs no earlier than the cycle after the push edge (1-cycle minimum latency).
REQ-020 md SHALL be unbuffered; md_ready = md_grant (combinational), md_grant = md_valid && commit_allowin && (all five FIFOs empty || md_wait == MD_MAX_WAIT).
REQ-021 On md_grant: commit_valid1=commit_valid2=1, commit_bus1=md_bus1, commit_bus2=md_bus2, no FIFO pops, RR pointers hold.
REQ-022 Otherwise lane 1 SHALL present head of alu1/bru FIFOs by 2-way round-robin; lane 2 SHALL present head of alu2/agu/spu FIFOs by 3-way round-robin.
REQ-023 Round-robin: search starts at pointer; on pop, pointer SHALL move to one past the granted source (wrap 1->0, 2->0).
REQ-024 When md_valid && md_wait == MD_MAX_WAIT, lane outputs SHALL be held invalid (commit_valid1/2=0) until md_grant.
REQ-025 commit_validN SHALL be 1 iff a candidate exists for lane N; commit_busN SHALL be 0 when commit_validN is 0.
REQ-026 Pop of presented heads SHALL occur only on commit_allowin; with commit_allowin=0 outputs remain stable, pointers hold.
REQ-027 md_wait (4-bit) SHALL increment each cycle md_valid && !md_grant, saturate at MD_MAX_WAIT, clear on md_grant or !md_valid.
REQ-028 Simultaneous push and pop on one FIFO SHALL keep count unchanged and preserve order.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 flush SHALL, at the edge, empty all FIFOs, clear md_wait and RR pointers; pushes in the flush cycle SHALL be dropped; md_ready SHALL be 0 during flush.

Reset
REQ-031 reset low SHALL immediately clear FIFOs, counts, md_wait, RR pointers; commit_valid1/2=0, commit_bus1/2=0, all src_ready=1, md_ready=0.
REQ-032 Deassertion SHALL be synchronised by the integration; block SHALL accept pushes on the first edge after release.

Verification
REQ-033 alu1 and bru push every cycle, commit_allowin=1 -> lane 1 alternates alu1,bru,alu1; no loss, per-source order kept.
REQ-034 alu2 pushes 2 entries with commit_allowin=0 -> alu2_ready=0 after second push; outputs stable; third valid not accepted until a pop.
REQ-035 md_valid with all FIFOs empty, commit_allowin=1 -> md_ready=1 same cycle, both lanes carry md_bus1/md_bus2.
REQ-036 md_valid held while agu streams continuously, MD_MAX_WAIT=8 -> after 8 cycles lane outputs drop, md granted on 9th cycle, md_wait=0.
REQ-037 FIFOs holding 3 entries, flush=1 one cycle -> next cycle commit_valid1/2=0, all src_ready=1, no stale entry ever emitted.
REQ-038 reset asserted mid-stream between edges -> outputs 0 immediately, after release first push appears after one cycle.
